// File: rtl/fir_out_sink.sv
// rtl/fir_out_sink.sv - FIR result sink: offset-binary to two's complement, decimate, buffer to consumer
module fir_out_sink #(
    parameter int OUT_WIDTH  = 16,
    parameter int OSR        = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH-1:0] in,
    input  logic                 valid,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overflow,
    output logic [CNT_W-1:0]     sample_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   phase, phase_nx;
    logic            push_req;

    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, pop, push_ok, drop;
    logic [OUT_WIDTH-1:0] conv;

    // IDLE always holds phase 0, so the first valid cycle is treated as phase 0
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        push_req = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_nx = RUN;
                    push_req = 1'b1;
                    phase_nx = (phase == PH_LAST) ? '0 : phase + PW'(1);
                end
            end
            RUN: begin
                if (valid) begin
                    push_req = (phase == '0);
                    phase_nx = (phase == PH_LAST) ? '0 : phase + PW'(1);
                end else begin
                    state_nx = IDLE;
                    phase_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
        end
    end

    assign conv    = {~in[OUT_WIDTH-1], in[OUT_WIDTH-2:0]};
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && m_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    assign m_valid = !empty;
    assign m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr[AW-1:0]] <= conv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (sample_cnt != {CNT_W{1'b1}}) begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_sink.sv
// tb/tb_fir_out_sink.sv - directed and random checks of fir_out_sink against a queue model
module tb_fir_out_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        valid;
    logic        m_ready;

    logic [15:0] d1, d4;
    logic        v1, v4, o1, o4;
    logic [15:0] c1, c4;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] q1[$];
    logic [15:0] q4[$];
    int          ph1, ph4;
    logic        ov1, ov4;
    logic [15:0] cnt1, cnt4;

    always #5 clk = ~clk;

    fir_out_sink #(.OUT_WIDTH(16), .OSR(1), .FIFO_DEPTH(8), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in(din), .valid(valid),
        .m_data(d1), .m_valid(v1), .m_ready(m_ready),
        .overflow(o1), .sample_cnt(c1)
    );

    fir_out_sink #(.OUT_WIDTH(16), .OSR(4), .FIFO_DEPTH(8), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .in(din), .valid(valid),
        .m_data(d4), .m_valid(v4), .m_ready(m_ready),
        .overflow(o4), .sample_cnt(c4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: model both instances from the spec rules, then compare after the edge
    task automatic step(input logic r, input logic vl, input logic [15:0] x, input logic rdy);
        rst = r; valid = vl; din = x; m_ready = rdy;
        if (!r) begin
            q1.delete(); q4.delete();
            ph1 = 0; ph4 = 0; ov1 = 0; ov4 = 0; cnt1 = 0; cnt4 = 0;
        end else begin
            if (q1.size() > 0 && rdy) void'(q1.pop_front());
            if (vl && ph1 == 0) begin
                if (q1.size() < 8) begin
                    q1.push_back(x ^ 16'h8000);
                    if (cnt1 != 16'hFFFF) cnt1++;
                end else ov1 = 1;
            end
            ph1 = vl ? (ph1 + 1) % 1 : 0;

            if (q4.size() > 0 && rdy) void'(q4.pop_front());
            if (vl && ph4 == 0) begin
                if (q4.size() < 8) begin
                    q4.push_back(x ^ 16'h8000);
                    if (cnt4 != 16'hFFFF) cnt4++;
                end else ov4 = 1;
            end
            ph4 = vl ? (ph4 + 1) % 4 : 0;
        end
        @(posedge clk);
        #1;
        check("m_valid_osr1", v1, q1.size() != 0);
        if (q1.size() != 0) check("m_data_osr1", d1, q1[0]);
        check("overflow_osr1", o1, ov1);
        check("cnt_osr1", c1, cnt1);
        check("m_valid_osr4", v4, q4.size() != 0);
        if (q4.size() != 0) check("m_data_osr4", d4, q4[0]);
        check("overflow_osr4", o4, ov4);
        check("cnt_osr4", c4, cnt4);
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; din = '0; m_ready = 1'b0;
        @(negedge clk);

        // reset state, with valid asserted to show it is ignored
        step(0, 1, 16'h1234, 0);
        check("rst_m_valid", v1, 0);
        check("rst_m_data", d1, 0);
        check("rst_overflow", o1, 0);
        check("rst_cnt", c4, 0);

        // conversion sequence at OSR=1
        step(1, 1, 16'h8000, 1);
        check("conv0", d1, 16'h0000);
        step(1, 1, 16'h7FFF, 1);
        check("conv1", d1, 16'hFFFF);
        step(1, 1, 16'h0000, 1);
        check("conv2", d1, 16'h8000);
        check("conv_cnt", c1, 3);

        // OSR=4 decimation of a ramp
        step(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 16'(i), 0);
        check("dec_cnt", c4, 3);
        check("dec_first", d4, 16'h8000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1);

        // phase restarts after valid drops
        step(0, 0, 0, 0);
        step(1, 1, 16'h0010, 0);
        step(1, 1, 16'h0011, 0);
        step(1, 0, 16'h0012, 0);
        step(1, 1, 16'h0013, 0);
        check("restart_cnt", c4, 2);

        // overflow on a full FIFO, then in-order drain
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 16'h0100 + 16'(i), 0);
        check("ovf_cnt", c1, 8);
        check("ovf_flag", o1, 1);
        check("ovf_head", d1, 16'h8100);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 1);
        check("ovf_drained", v1, 0);

        // push and pop together on a full FIFO
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 16'h0200 + 16'(i), 0);
        step(1, 1, 16'h0300, 1);
        check("full_pp_ovf", o1, 0);
        check("full_pp_cnt", c1, 9);
        check("full_pp_head", d1, 16'h8201);

        // mid-stream reset flushes buffered samples
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 16'h0400 + 16'(i), 0);
        step(0, 1, 16'h0500, 1);
        check("flush_m_valid", v1, 0);
        check("flush_cnt", c1, 0);
        check("flush_ovf", o1, 0);
        step(1, 0, 0, 1);
        check("flush_after", v1, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 8),
                 16'($urandom),
                 ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
